// File: rtl/hs32_pkg.sv
// Shared hs32 fetch definitions: entry layout, instruction size and reset PC.
package hs32_pkg;

  localparam int unsigned HS32_WIDTH          = 32;
  localparam int unsigned HS32_AWIDTH         = 32;
  localparam int unsigned HS32_BYTES_PER_INST = HS32_WIDTH / 8;
  localparam logic [HS32_AWIDTH-1:0] HS32_RESET_PC = '0;

  typedef struct packed {
    logic [HS32_WIDTH-1:0]  inst;
    logic [HS32_AWIDTH-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/hs32_sync_fifo.sv
// Synchronous FIFO with extra-bit pointers, combinational head read and a
// one-cycle flush that discards every queued entry.
module hs32_sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DBITS = 2,
  parameter int unsigned DW    = 64
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           push,
  input  logic [DW-1:0]  din,
  input  logic           pop,
  input  logic           flush,
  output logic [DW-1:0]  dout,
  output logic [DBITS:0] count,
  output logic           full,
  output logic           empty
);

  logic [DW-1:0]  r_mem [DEPTH];
  logic [DBITS:0] r_wp;
  logic [DBITS:0] r_rp;
  logic           w_do_push;
  logic           w_do_pop;

  assign w_do_push = push && !flush && !full;
  assign w_do_pop  = pop && !flush && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_do_push) r_wp <= r_wp + 1'b1;
      if (flush) r_rp <= r_wp;
      else if (w_do_pop) r_rp <= r_rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wp[DBITS-1:0]] <= din;
  end

  assign dout  = r_mem[r_rp[DBITS-1:0]];
  assign count = r_wp - r_rp;
  assign full  = (count == (DBITS+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/hs32_fetch_q.sv
// hs32 prefetch queue: sequential fetch issue, PC-tagged buffering and
// flush/redirect with stale-response drop. Optional FETCH_STATS_EN adds counters.
module hs32_fetch_q
  import hs32_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DBITS  = 2,
  parameter int unsigned WIDTH  = HS32_WIDTH,
  parameter int unsigned AWIDTH = HS32_AWIDTH,
  parameter logic [AWIDTH-1:0] RESET_PC = AWIDTH'(HS32_RESET_PC)
) (
  input  logic              clk,
  input  logic              reset,
  output logic [AWIDTH-1:0] addr,
  input  logic [WIDTH-1:0]  dtr,
  output logic              reqm,
  input  logic              ackm,
  output logic [WIDTH-1:0]  instd,
  output logic [AWIDTH-1:0] pcd,
  output logic              ackd,
  input  logic              reqd,
  input  logic [AWIDTH-1:0] newpc,
  input  logic              flush
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [15:0]       flush_cnt
`endif
);

  localparam logic [AWIDTH-1:0] ADDR_INC = AWIDTH'(WIDTH / 8);

  logic [AWIDTH-1:0]       r_addr;
  logic                    r_reqm;
  logic                    r_discard;
  logic [AWIDTH-1:0]       r_redirect;

  logic [DBITS:0]          w_count;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_pop;
  logic                    w_ack;
  logic                    w_push;
  logic [DBITS:0]          w_fill_next;
  logic                    w_issue_ok;
  logic [WIDTH+AWIDTH-1:0] w_head;

  assign w_ack  = ackm && r_reqm;
  assign w_push = w_ack && !r_discard && !flush;
  assign w_pop  = reqd && !w_empty && !flush;

  // A request may be outstanding next cycle only if its push cannot overflow.
  assign w_fill_next = flush ? '0
                     : w_count + (DBITS+1)'(w_push) - (DBITS+1)'(w_pop);
  assign w_issue_ok  = (w_fill_next < (DBITS+1)'(DEPTH));

  hs32_sync_fifo #(
    .DEPTH (DEPTH),
    .DBITS (DBITS),
    .DW    (WIDTH + AWIDTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .din   ({dtr, r_addr}),
    .pop   (w_pop),
    .flush (flush),
    .dout  (w_head),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr     <= RESET_PC;
      r_reqm     <= 1'b0;
      r_discard  <= 1'b0;
      r_redirect <= '0;
    end else if (flush) begin
      if (r_reqm && !ackm) begin
        // Keep the in-flight address stable; retarget once its ack lands.
        r_discard  <= 1'b1;
        r_redirect <= newpc;
      end else begin
        r_addr    <= newpc;
        r_discard <= 1'b0;
        r_reqm    <= w_issue_ok;
      end
    end else if (w_ack) begin
      if (r_discard) begin
        r_addr    <= r_redirect;
        r_discard <= 1'b0;
      end else begin
        r_addr <= r_addr + ADDR_INC;
      end
      r_reqm <= w_issue_ok;
    end else if (!r_reqm) begin
      r_reqm <= w_issue_ok;
    end
  end

  assign addr  = r_addr;
  assign reqm  = r_reqm;
  assign ackd  = !w_empty;
  assign instd = w_head[WIDTH+AWIDTH-1:AWIDTH];
  assign pcd   = w_head[AWIDTH-1:0];

`ifdef FETCH_STATS_EN
  logic [31:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (reqd && w_empty && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (flush && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

  logic w_unused;
  assign w_unused = w_full;

endmodule
